sync_fifo_stream_rd: RTL
========================

# sync_fifo_stream_rd

Read-side adapter placed directly downstream of the team's pointer-based synchronous FIFO. It drives the FIFO's `rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents the data as a valid/ready stream with full one-word-per-cycle throughput. It uses a 3-entry prefetch buffer so that no combinational path runs from `m_ready` to `fifo_rd_en`.

## Interface
- `DATA_WIDTH`, default 8: width of FIFO words and stream data.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`. It is registered and valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  read request to the FIFO.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DATA_WIDTH  stream data.
- `buf_level`  out  2  number of words held in the prefetch buffer (0..3).

## Operation
- **FIFO contract**
  - A read is accepted when `fifo_rd_en && !fifo_empty`.
  - Accepted data appears on `fifo_data` on the next cycle.
  - `fifo_rd_en` while empty is ignored by the FIFO, and the adapter does not count it.
- **State**
  - `mem[0:2]`, each DATA_WIDTH.
  - `wr_idx` and `rd_idx`, each 2 bits, range 0..2. An index at 2 wraps to 0, not at 3.
  - `count`, 2 bits.
  - `in_flight`, 1 bit.
- **Issue:** `fifo_rd_en = !fifo_empty && (count + in_flight <= 2)`. The addition is 3 bits wide. The expression is a function of registers and `fifo_empty` only.
- **In-flight flag:** `in_flight` is registered as `fifo_rd_en && !fifo_empty`.
- **Capture:** when `in_flight` = 1, write `fifo_data` to `mem[wr_idx]` and advance `wr_idx`.
- **Pop:** `pop = m_valid && m_ready`. On pop, advance `rd_idx`.
- **Count:** `count_next = count + in_flight - pop`. This covers simultaneous capture and pop.
- **Invariant:** `count + in_flight <= 3`. `count` never exceeds 3 and never underflows. The bench asserts this.
- **Outputs:**
  - `m_valid = (count != 0)`.
  - `m_data = mem[rd_idx]`.
  - `buf_level = count`.
- **No bypass:** a captured word is never presented on the same cycle it is captured.
- **Stream rule:** while `m_valid && !m_ready`, `m_data` and `m_valid` hold stable.
- **Ordering:** words leave in FIFO order; none are dropped or duplicated.

## Timing
- **Reset** (synchronous, sampled at a `clk` edge with `rst_n` = 0):
  - `count`, `in_flight`, `wr_idx`, `rd_idx` and every `mem` entry go to 0.
  - Outputs: `m_valid` = 0, `m_data` = 0, `buf_level` = 0.
  - `fifo_rd_en` is forced to 0 during reset.
- **Latency:** FIFO becomes non-empty in cycle T with the adapter idle. Then `fifo_rd_en` = 1 in T, capture at the end of T+1, and `m_valid` = 1 in T+2.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, the steady state is `count` = 1, `in_flight` = 1, and one word per cycle.
- **Backpressure:** with `m_ready` = 0, reads stop once `count + in_flight` = 3. The buffer then fills to 3 and the FIFO retains the remainder.
- **FIFO drains mid-burst:** `fifo_rd_en` drops the cycle `fifo_empty` rises. Buffered words continue to drain.
- **Reset mid-operation:**
  - Buffered and in-flight words are discarded.
  - The FIFO shares `rst_n`, so both sides restart empty.
  - No capture occurs in the cycle after reset, even if a read was accepted in the last pre-reset cycle.

## Structure
- Shared package `sync_fifo_pkg` holds:
  - `FIFO_RD_LATENCY` = 1.
  - `STREAM_BUF_DEPTH` = 3.
  - A helper function for the wrap-at-2 index increment.
- One sub-module is natural: `stream_prefetch_buf`. It is the 3-entry circular buffer with push, pop, count and data-out.
- The top level holds only the issue logic and the `in_flight` register.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with the FIFO pre-filled. Require `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0 and `buf_level` = 0 throughout.
- **Streaming:** write 16 words 0x00..0x0F, then hold `m_ready` = 1. Require the first `m_valid` 2 cycles after `fifo_empty` falls. Then 16 consecutive pops carrying 0x00..0x0F with no gap.
- **Backpressure:** `m_ready` = 0 with 10 words queued. Require `buf_level` = 3, `fifo_rd_en` = 0 and `m_data` = 0x00 stable. Release `m_ready`; require all 10 words in order with none lost.
- **Random ready:** `m_ready` toggles randomly over 200 words. Require the scoreboard to match in order, `buf_level` ≤ 3, and the count invariant to hold every cycle.
- **Single word:** 1 word into an empty FIFO. Require exactly one `fifo_rd_en` pulse, one pop of the correct value, then `m_valid` = 0 and `buf_level` = 0.
- **Reset mid-burst:** assert `rst_n` = 0 for one cycle while `in_flight` = 1 and `buf_level` = 2. Require all outputs at reset values next cycle and no stale capture. A fresh write of 0xA5 afterwards streams out as 0xA5.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Buffer indices run 0..STREAM_BUF_DEPTH-1 and wrap at the last entry, not at 3.
package sync_fifo_pkg;

    localparam int FIFO_RD_LATENCY  = 1;
    localparam int STREAM_BUF_DEPTH = 3;

    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'(STREAM_BUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/stream_prefetch_buf.sv
// Three-entry circular prefetch buffer: push captures a word, pop advances the
// read pointer, and data_out always shows the oldest held word.
module stream_prefetch_buf
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem_q [STREAM_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [STREAM_BUF_DEPTH];
    logic [1:0]            wr_idx_q, wr_idx_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (push) begin
            mem_d[wr_idx_q] = push_data;
            wr_idx_d        = idx_inc(wr_idx_q);
        end
        if (pop) begin
            rd_idx_d = idx_inc(rd_idx_q);
        end
        // Simultaneous push and pop leave the level unchanged.
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STREAM_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= 2'd0;
            rd_idx_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign count    = count_q;
    assign data_out = mem_q[rd_idx_q];

endmodule

// File: rtl/sync_fifo_stream_rd.sv
// Read-side adapter for the registered-output synchronous FIFO: issues rd_en,
// tracks the one in-flight read, and presents a valid/ready stream.
module sync_fifo_stream_rd
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_level
);

    logic       in_flight_q, in_flight_d;
    logic [1:0] count;
    logic [2:0] pending;
    logic       pop;

    // Issue depends only on registered state and fifo_empty, so m_ready never
    // reaches fifo_rd_en combinationally.
    always_comb begin
        pending     = {1'b0, count} + {2'b00, in_flight_q};
        fifo_rd_en  = rst_n && !fifo_empty && (pending <= 3'd2);
        in_flight_d = fifo_rd_en && !fifo_empty;
        m_valid     = (count != 2'd0);
        pop         = m_valid && m_ready;
        buf_level   = count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    stream_prefetch_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_flight_q),
        .push_data(fifo_data),
        .pop      (pop),
        .count    (count),
        .data_out (m_data)
    );

endmodule
